pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 169 ++++++++++++++++
 tb/tb_pll_reset_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock qualified, staggered multi-channel reset sequencer
// Optional loss-of-lock counter port loss_count enabled by macro PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_seq #(
    parameter int NUM_RST            = 2,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               lock,
    input  logic               sw_reset,
    output logic [NUM_RST-1:0] reset,
    output logic               ready,
    output logic               lock_lost
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]         loss_count
`endif
);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

    localparam logic [15:0] CNT_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]  STAG_LAST = 8'(STAGGER_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST  = 4'(NUM_RST - 1);

    state_t               r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 w_lock_s;
    logic [15:0]          r_cnt, w_cnt_nxt;
    logic [7:0]           r_stag, w_stag_nxt;
    logic [3:0]           r_idx, w_idx_nxt, w_idx_inc;
    logic [NUM_RST-1:0]   r_reset, w_reset_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_lock_lost, w_lock_lost_nxt;
    logic                 w_enter_rel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], lock};
        end
    end

    assign w_lock_s  = r_sync[SYNC_STAGES-1];
    assign w_idx_inc = r_idx + 4'd1;

    // The WAIT_LOCK->STABLE edge already counts as the first stable cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_stag_nxt      = r_stag;
        w_idx_nxt       = r_idx;
        w_reset_nxt     = r_reset;
        w_ready_nxt     = r_ready;
        w_lock_lost_nxt = r_lock_lost;
        w_enter_rel     = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                w_reset_nxt = '1;
                w_ready_nxt = 1'b0;
                w_cnt_nxt   = '0;
                if (!sw_reset && w_lock_s) begin
                    if (LOCK_STABLE_CYCLES == 1) begin
                        w_enter_rel = 1'b1;
                    end else begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = 16'd1;
                    end
                end
            end
            STABLE: begin
                if (sw_reset || !w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_enter_rel = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                if (!w_lock_s || sw_reset) begin
                    w_state_nxt = WAIT_LOCK;
                    w_reset_nxt = '1;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_stag_nxt  = '0;
                    w_idx_nxt   = '0;
                    if (!w_lock_s) begin
                        w_lock_lost_nxt = 1'b1;
                    end
                end else if (r_state == RELEASE) begin
                    if (r_stag == STAG_LAST) begin
                        w_stag_nxt = '0;
                        w_idx_nxt  = w_idx_inc;
                        for (int i = 0; i < NUM_RST; i++) begin
                            if (4'(i) == w_idx_inc) begin
                                w_reset_nxt[i] = 1'b0;
                            end
                        end
                        if (w_idx_inc == IDX_LAST) begin
                            w_ready_nxt = 1'b1;
                            w_state_nxt = RUN;
                        end
                    end else begin
                        w_stag_nxt = r_stag + 8'd1;
                    end
                end
            end
        endcase
        if (w_enter_rel) begin
            w_state_nxt    = RELEASE;
            w_cnt_nxt      = '0;
            w_stag_nxt     = '0;
            w_idx_nxt      = '0;
            w_reset_nxt    = '1;
            w_reset_nxt[0] = 1'b0;
            if (NUM_RST == 1) begin
                w_ready_nxt = 1'b1;
                w_state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_stag      <= '0;
            r_idx       <= '0;
            r_reset     <= '1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stag      <= w_stag_nxt;
            r_idx       <= w_idx_nxt;
            r_reset     <= w_reset_nxt;
            r_ready     <= w_ready_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign reset     = r_reset;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_evt;

    assign w_loss_evt = ((r_state == RELEASE) || (r_state == RUN)) && !w_lock_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - randomized self-checking bench for pll_reset_seq
module tb_pll_reset_seq;
    localparam int N  = 3;
    localparam int S  = 2;
    localparam int L  = 8;
    localparam int ST = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         lock = 1'b0;
    logic         sw_reset = 1'b0;
    logic [N-1:0] reset;
    logic         ready;
    logic         lock_lost;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [7:0]   loss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_edge  = 0;

    // Reference: timestamps since release instead of channel/state tracking.
    int m_sync[S];
    bit m_released;
    int m_age;
    int m_run;
    bit m_lost;
    int m_loss;

    pll_reset_seq #(
        .NUM_RST(N), .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .STAGGER_CYCLES(ST)
    ) dut (
        .clock(clock), .reset_n(reset_n), .lock(lock), .sw_reset(sw_reset),
        .reset(reset), .ready(ready), .lock_lost(lock_lost)
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
        , .loss_count(loss_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n_edge, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_sync[i] = 0;
        m_released = 0;
        m_age = 0;
        m_run = 0;
        m_lost = 0;
        m_loss = 0;
    endtask

    task automatic model_edge(input logic l, input logic s);
        int ls;
        ls = m_sync[S-1];
        if (m_released) begin
            if (ls == 0) begin
                m_lost = 1;
                if (m_loss < 255) m_loss++;
                m_released = 0;
                m_run = 0;
            end else if (s) begin
                m_released = 0;
                m_run = 0;
            end else if (m_age < 10000) begin
                m_age++;
            end
        end else begin
            if (s || ls == 0) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == L) begin
                    m_released = 1;
                    m_age = 0;
                    m_run = 0;
                end
            end
        end
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = int'(l);
    endtask

    function automatic logic [N-1:0] exp_reset();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !(m_released && (m_age >= i * ST));
        return r;
    endfunction

    task automatic check_model();
        check_eq("reset", 32'(reset), 32'(exp_reset()));
        check_eq("ready", 32'(ready), 32'(m_released && (m_age >= (N - 1) * ST)));
        check_eq("lock_lost", 32'(lock_lost), 32'(m_lost));
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
        check_eq("loss_count", 32'(loss_count), 32'(m_loss));
`endif
    endtask

    // Entered and left on a falling edge; inputs applied half a cycle before the sampling edge.
    task automatic step(input logic l, input logic s);
        lock = l;
        sw_reset = s;
        @(posedge clock);
        n_edge++;
        model_edge(l, s);
        @(negedge clock);
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        lock = 1'b0;
        sw_reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        n_edge = 0;
    endtask

    task automatic async_pulse();
        reset_n = 1'b0;
        #1;
        check_eq("async_reset", 32'(reset), 32'(3'b111));
        check_eq("async_ready", 32'(ready), 32'd0);
        check_eq("async_lost", 32'(lock_lost), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        n_edge = 0;
    endtask

    task automatic run_release(output int t0, output int t1, output int t2, output int tr);
        t0 = -1; t1 = -1; t2 = -1; tr = -1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            if (t0 < 0 && reset[0] == 1'b0) t0 = n_edge;
            if (t1 < 0 && reset[1] == 1'b0) t1 = n_edge;
            if (t2 < 0 && reset[2] == 1'b0) t2 = n_edge;
            if (tr < 0 && ready == 1'b1) tr = n_edge;
        end
    endtask

    initial begin
        int t0, t1, t2, tr;
        do_reset();
        check_eq("rst_reset", 32'(reset), 32'(3'b111));
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_lost", 32'(lock_lost), 32'd0);

        // Nominal release timing
        run_release(t0, t1, t2, tr);
        check_eq("rel0_edge", 32'(t0), 32'd10);
        check_eq("rel1_edge", 32'(t1), 32'd14);
        check_eq("rel2_edge", 32'(t2), 32'd18);
        check_eq("ready_edge", 32'(tr), 32'd18);

        // One-cycle glitch on lock at edge 6 restarts qualification
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step((k == 6) ? 1'b0 : 1'b1, 1'b0);
            if (k == 15) check_eq("glitch_hold", 32'(reset[0]), 32'd1);
            if (k == 16) check_eq("glitch_rel0", 32'(reset[0]), 32'd0);
        end

        // Lock loss in RUN, coinciding with sw_reset on the reacting edge
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("loss_ready_held", 32'(ready), 32'd1);
        step(1'b0, 1'b1);
        check_eq("loss_reset", 32'(reset), 32'(3'b111));
        check_eq("loss_ready", 32'(ready), 32'd0);
        check_eq("loss_sticky", 32'(lock_lost), 32'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        check_eq("loss_still_sticky", 32'(lock_lost), 32'd1);

        // sw_reset pulse in RUN
        do_reset();
        run_release(t0, t1, t2, tr);
        step(1'b1, 1'b1);
        check_eq("sw_reset_all", 32'(reset), 32'(3'b111));
        check_eq("sw_lost_clear", 32'(lock_lost), 32'd0);
        n_edge = 0;
        run_release(t0, t1, t2, tr);
        check_eq("sw_rel0_edge", 32'(t0), 32'd8);
        check_eq("sw_ready_edge", 32'(tr), 32'd16);

        // Async reset during RELEASE
        do_reset();
        for (int k = 0; k < 11; k++) step(1'b1, 1'b0);
        check_eq("mid_release", 32'(reset), 32'(3'b110));
        async_pulse();
        run_release(t0, t1, t2, tr);
        check_eq("restart_rel0", 32'(t0), 32'd10);
        check_eq("restart_ready", 32'(tr), 32'd18);

        // Randomized lock / sw_reset traffic against the reference
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int hi, lo;
            hi = $urandom_range(1, 40);
            lo = $urandom_range(1, 4);
            for (int k = 0; k < hi; k++) step(1'b1, $urandom_range(0, 29) == 0);
            for (int k = 0; k < lo; k++) step(1'b0, $urandom_range(0, 9) == 0);
            if (seg % 15 == 7) async_pulse();
        end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
        do_reset();
        for (int ev = 0; ev < 300; ev++) begin
            for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        end
        check_eq("loss_saturate", 32'(loss_count), 32'd255);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        check_eq("loss_hold", 32'(loss_count), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
